// File: rtl/cpu_press_gen.sv
// Computer-player button generator: a level+rnd carry-out trigger produces a single-cycle press followed by a cooldown.
// Define CPU_PRESS_CNT_EN to add the saturating press_cnt output.
module cpu_press_gen #(
    parameter int WIDTH    = 9,
    parameter int COOLDOWN = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] level,
    input  logic [WIDTH-1:0] rnd,
    output logic             press,
    output logic             busy
`ifdef CPU_PRESS_CNT_EN
    ,
    output logic [7:0]       press_cnt
`endif
);

    localparam int CW = (COOLDOWN < 2) ? 1 : $clog2(COOLDOWN + 1);
    localparam logic [CW-1:0] COOL_LOAD = (COOLDOWN > 0) ? CW'(COOLDOWN - 1) : '0;
    localparam logic [WIDTH:0] THRESH = (WIDTH + 1)'(1 << WIDTH);

    typedef enum logic [1:0] {
        ARMED = 2'd0,
        PRESS = 2'd1,
        COOL  = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [CW-1:0]   cool_cnt, cool_d;
    logic [WIDTH:0]  sum;
    logic            trigger;
    logic            trig_q;

    // Carry into bit WIDTH is the trigger; the widened sum can never wrap.
    assign sum     = {1'b0, level} + {1'b0, rnd};
    assign trigger = (sum >= THRESH);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trig_q <= 1'b0;
        end else begin
            trig_q <= trigger & en;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ARMED;
            cool_cnt <= '0;
            press    <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_d;
            cool_cnt <= cool_d;
            press    <= (state_d == PRESS);
            busy     <= (state_d != ARMED);
        end
    end

    always_comb begin
        state_d = state;
        cool_d  = cool_cnt;
        case (state)
            ARMED: begin
                if (trig_q) state_d = PRESS;
            end
            PRESS: begin
                if (COOLDOWN > 0) begin
                    state_d = COOL;
                    cool_d  = COOL_LOAD;
                end else begin
                    state_d = ARMED;
                end
            end
            COOL: begin
                if (cool_cnt == '0) state_d = ARMED;
                else                cool_d  = cool_cnt - CW'(1);
            end
            default: state_d = ARMED;
        endcase
    end

`ifdef CPU_PRESS_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            press_cnt <= '0;
        end else if (state == ARMED && state_d == PRESS && press_cnt != 8'hFF) begin
            press_cnt <= press_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu_press_gen.sv
// Directed self-checking bench for cpu_press_gen (COOLDOWN=4 main instance, COOLDOWN=0 second instance).
// Counter checks run when CPU_PRESS_CNT_EN is defined.
module tb_cpu_press_gen;

    logic       clk;
    logic       reset;
    logic       en;
    logic [8:0] level;
    logic [8:0] rnd;
    logic       press, busy;
    logic       press2, busy2;
`ifdef CPU_PRESS_CNT_EN
    logic [7:0] press_cnt, press_cnt2;
`endif

    int checks = 0;
    int passed = 0;

    cpu_press_gen #(.WIDTH(9), .COOLDOWN(4)) dut (
        .clk(clk), .reset(reset), .en(en), .level(level), .rnd(rnd),
        .press(press), .busy(busy)
`ifdef CPU_PRESS_CNT_EN
        , .press_cnt(press_cnt)
`endif
    );

    cpu_press_gen #(.WIDTH(9), .COOLDOWN(0)) dut0 (
        .clk(clk), .reset(reset), .en(en), .level(level), .rnd(rnd),
        .press(press2), .busy(busy2)
`ifdef CPU_PRESS_CNT_EN
        , .press_cnt(press_cnt2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle();
        en = 1'b0; level = '0; rnd = '0;
        repeat (10) tick();
    endtask

    task automatic test_reset();
        reset = 1'b0; en = 1'b1; level = 9'h1FF; rnd = 9'h1FF;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (press !== 1'b0 || busy !== 1'b0)
                $display("FAIL reset_hold[%0d]: press=%b busy=%b required 0/0", i, press, busy);
            else passed++;
        end
        reset = 1'b1;
        tick();
        checks++;
        if (press !== 1'b0) $display("FAIL reset_rel1: press=%b required 0", press);
        else passed++;
        tick();
        checks++;
        if (press !== 1'b1 || busy !== 1'b1)
            $display("FAIL reset_rel2: press=%b busy=%b required 1/1", press, busy);
        else passed++;
        idle();
    endtask

    task automatic test_threshold();
        int hits;
        en = 1'b1; level = 9'd1; rnd = 9'd510;
        hits = 0;
        repeat (8) begin tick(); if (press) hits++; end
        checks++;
        if (hits !== 0) $display("FAIL thr_511: presses=%0d required 0", hits);
        else passed++;
        level = 9'd2; rnd = 9'd510;
        tick();
        level = '0; rnd = '0;
        checks++;
        if (press !== 1'b0) $display("FAIL thr_512_n: press=%b required 0", press);
        else passed++;
        tick();
        checks++;
        if (press !== 1'b1) $display("FAIL thr_512_n1: press=%b required 1", press);
        else passed++;
        tick();
        checks++;
        if (press !== 1'b0) $display("FAIL thr_512_n2: press=%b required 0", press);
        else passed++;
        idle();
        en = 1'b1; level = 9'd2; rnd = 9'h101;
        hits = 0;
        repeat (8) begin tick(); if (press) hits++; end
        checks++;
        if (hits !== 0) $display("FAIL thr_259: presses=%0d required 0", hits);
        else passed++;
        idle();
    endtask

    task automatic test_no_wrap();
        int hits;
        en = 1'b1; level = 9'h1FF; rnd = 9'h1FF;
        tick();
        level = '0;
        tick();
        checks++;
        if (press !== 1'b1) $display("FAIL nowrap_1022: press=%b required 1", press);
        else passed++;
        idle();
        en = 1'b1; level = '0; rnd = 9'h1FF;
        hits = 0;
        repeat (10) begin tick(); if (press) hits++; end
        checks++;
        if (hits !== 0) $display("FAIL nowrap_511: presses=%0d required 0", hits);
        else passed++;
        idle();
    endtask

    task automatic test_cooldown();
        logic ep, eb, ep2;
        en = 1'b1; level = 9'd300; rnd = 9'd300;
        for (int k = 0; k < 25; k++) begin
            tick();
            ep  = (k >= 1) && ((k - 1) % 6 == 0);
            eb  = (k >= 1) && ((k - 1) % 6 != 5);
            ep2 = (k % 2 == 1);
            checks++;
            if (press !== ep || busy !== eb)
                $display("FAIL cool4[%0d]: press=%b busy=%b required %b/%b", k, press, busy, ep, eb);
            else passed++;
            checks++;
            if (press2 !== ep2 || busy2 !== ep2)
                $display("FAIL cool0[%0d]: press=%b busy=%b required %b/%b", k, press2, busy2, ep2, ep2);
            else passed++;
        end
        idle();
    endtask

    task automatic test_enable();
        int hits;
        logic eb;
        en = 1'b0; level = 9'd300; rnd = 9'd300;
        hits = 0;
        repeat (20) begin tick(); if (press || busy) hits++; end
        checks++;
        if (hits !== 0) $display("FAIL en_off: active_cycles=%0d required 0", hits);
        else passed++;
        en = 1'b1;
        tick();
        tick();
        checks++;
        if (press !== 1'b1) $display("FAIL en_press: press=%b required 1", press);
        else passed++;
        tick();
        en = 1'b0;
        for (int k = 2; k < 16; k++) begin
            if (k > 2) tick();
            eb = (k <= 5);
            checks++;
            if (busy !== eb || press !== 1'b0)
                $display("FAIL en_cool[%0d]: busy=%b press=%b required %b/0", k, busy, press, eb);
            else passed++;
        end
        en = 1'b1;
        tick();
        tick();
        checks++;
        if (press !== 1'b1) $display("FAIL en_resume: press=%b required 1", press);
        else passed++;
        idle();
    endtask

    task automatic test_async_reset_and_count();
        int seen;
        int cyc;
        en = 1'b1; level = 9'd300; rnd = 9'd300;
        tick();
        tick();
        checks++;
        if (press !== 1'b1) $display("FAIL arst_pre: press=%b required 1", press);
        else passed++;
        #2 reset = 1'b0;
        #1;
        checks++;
        if (press !== 1'b0 || busy !== 1'b0)
            $display("FAIL arst_drop: press=%b busy=%b required 0/0", press, busy);
        else passed++;
`ifdef CPU_PRESS_CNT_EN
        checks++;
        if (press_cnt !== 8'h00) $display("FAIL arst_cnt: press_cnt=%0h required 0", press_cnt);
        else passed++;
`endif
        tick();
        reset = 1'b1;
        seen = 0;
        cyc = 0;
        while (seen < 300 && cyc < 2500) begin
            tick();
            cyc++;
            if (press) begin
                seen++;
`ifdef CPU_PRESS_CNT_EN
                if (seen == 1 || seen == 100 || seen == 255 || seen == 256 || seen == 300) begin
                    checks++;
                    if (press_cnt !== ((seen > 255) ? 8'hFF : 8'(seen)))
                        $display("FAIL cnt[%0d]: press_cnt=%0h required %0h", seen, press_cnt,
                                 (seen > 255) ? 8'hFF : 8'(seen));
                    else passed++;
                end
`endif
            end
        end
        checks++;
        if (seen !== 300) $display("FAIL pulse_budget: pulses=%0d required 300", seen);
        else passed++;
        idle();
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; level = '0; rnd = '0;
        test_reset();
        test_threshold();
        test_no_wrap();
        test_cooldown();
        test_enable();
        test_async_reset_and_count();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cpu_press_gen.md
Name: cpu_press_gen

Overview:
- Parametrised computer-player button generator for the game labs.
- Each cycle it adds a difficulty level (from switches) to a random sample (from the LFSR) and checks whether the unsigned sum reaches 2^WIDTH.
- A qualifying sum produces a clean, single-cycle press pulse, followed by a programmable cooldown.
- The press output feeds the same user-input path as a debounced player key.

Parameters:
WIDTH, 9, bit width of level and rnd; legal range 2..16
COOLDOWN, 4, cycles press stays locked out after each pulse; legal range 0..255

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous active-low reset (asserted when 0)
en  input  1  generator enable; 0 suppresses new triggers
level  input  WIDTH  difficulty value (switches), unsigned
rnd  input  WIDTH  random sample (LFSR), unsigned
press  output  1  registered one-cycle press pulse
busy  output  1  high while in PRESS or COOL
press_cnt  output  8  saturating press count (present only with CPU_PRESS_CNT_EN)

Behaviour:
- Arithmetic:
  - sum = {1'b0,level} + {1'b0,rnd}, WIDTH+1 bits, no truncation.
  - trigger = sum[WIDTH], i.e. sum >= 2^WIDTH.
  - Max sum 2^(WIDTH+1)-2 never wraps.
- Stage 1: trig_q <= trigger & en on every rising edge.
- FSM (Moore, registered outputs), states ARMED, PRESS, COOL:
  - ARMED: trig_q=1 -> PRESS; else stay.
  - PRESS: press=1 for exactly one cycle.
    - COOLDOWN>0 -> COOL, load cool_cnt = COOLDOWN-1.
    - COOLDOWN=0 -> ARMED.
  - COOL: trig_q ignored. If cool_cnt=0 -> ARMED; else decrement.
    - cool_cnt width = $clog2(COOLDOWN+1), minimum 1.
- Latency: inputs sampled at edge n -> trig_q at n -> PRESS at n+1. press is high between edges n+1 and n+2.
- Continuous trigger: one pulse every COOLDOWN+2 cycles. COOLDOWN=0 gives a pulse every 2 cycles; press is never high on two consecutive cycles.
- busy = (state != ARMED), registered alongside state.
- en=0:
  - trig_q forced 0 next edge.
  - A PRESS already entered completes, and COOL runs to completion.
  - en does not affect cool_cnt.
- A trigger arriving during PRESS or COOL is dropped, not queued.
- Reset (reset=0, async, no clock needed):
  - state=ARMED, trig_q=0, cool_cnt=0, press=0, busy=0, press_cnt=0.
  - Reset mid-PRESS drops press immediately.
  - After release, the first possible press is 2 edges later.
- level/rnd are treated as synchronous to clk; no internal synchroniser.

Optional Feature:
- Macro CPU_PRESS_CNT_EN.
- Defined:
  - press_cnt port exists.
  - It increments by 1 on each ARMED->PRESS transition and saturates at 8'hFF.
  - It is cleared only by reset.
- Undefined: press_cnt port and counter logic are absent; all other behaviour is identical.

Test Plan:
1. Reset: hold reset=0 with level=9'h1FF, rnd=9'h1FF, en=1 for 5 edges -> press=0, busy=0 throughout. Release -> press high on the 2nd cycle after release.
2. Threshold boundary (WIDTH=9, en=1):
   - level=1, rnd=510 (sum 511) -> no press.
   - level=2, rnd=510 (sum 512) -> press high exactly 1 cycle, 2 edges after the sampling edge.
   - level=2, rnd=9'h101 (sum 259) -> no press.
3. No-wrap check: level=9'h1FF, rnd=9'h1FF (sum 1022) -> press asserted. level=0, rnd=9'h1FF -> never asserted.
4. Cooldown spacing, trigger held continuously:
   - COOLDOWN=4 -> press pulses exactly 6 cycles apart, busy high 5 of every 6 cycles.
   - COOLDOWN=0 -> pulses 2 cycles apart, busy high on every press cycle only.
5. Enable gating:
   - en=0 with sum=600 for 20 cycles -> no press.
   - Drop en to 0 in the first COOL cycle -> COOL completes on schedule, busy falls after 4 COOL cycles, no further press until en=1.
6. Async reset mid-pulse and counter (CPU_PRESS_CNT_EN defined):
   - Assert reset=0 between edges while press=1 -> press and busy go 0 with no clock edge, press_cnt=0.
   - 300 triggered pulses -> press_cnt saturates at 8'hFF.
